// File: rtl/maxpool2d_2x2_stride2x2_pkg.sv
// Shared FP32 constants and the order-preserving key used by the pooling
// comparators and by the convolution stage's debug compare.
package maxpool2d_2x2_stride2x2_pkg;

  localparam int FP32_WIDTH    = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam logic [FP32_WIDTH-1:0] FP32_POS_ZERO = 32'h0000_0000;

  // Negative values invert all bits, positive values flip the sign bit, so an
  // unsigned compare of keys orders -NaN < -inf < ... < -0 < +0 < ... < +NaN.
  function automatic logic [FP32_WIDTH-1:0] fp32_key(input logic [FP32_WIDTH-1:0] x);
    return x[FP32_SIGN_BIT] ? ~x : {1'b1, x[FP32_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/maxpool2d_2x2_stride2x2_fp32_max2.sv
// Combinational FP32 max of two operands under the total key order;
// a tie returns operand a.
module fp32_max2
  import maxpool2d_2x2_stride2x2_pkg::*;
(
  input  logic [FP32_WIDTH-1:0] a,
  input  logic [FP32_WIDTH-1:0] b,
  output logic [FP32_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    if (fp32_key(b) > fp32_key(a)) y = b;
  end

endmodule

// File: rtl/maxpool2d_2x2_stride2x2.sv
// Streaming 2x2 stride-2 FP32 max-pool over a raster stream, one pixel/cycle.
// Optional fused ReLU on the pooled value: define MAXPOOL_FUSED_RELU_EN.
module maxpool2d_2x2_stride2x2
  import maxpool2d_2x2_stride2x2_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int IN_WIDTH   = 218,
  parameter int IN_HEIGHT  = 218
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int COL_W    = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W    = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_DEPTH = IN_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam bit W_ODD    = (IN_WIDTH  % 2) == 1;
  localparam bit H_ODD    = (IN_HEIGHT % 2) == 1;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IN_HEIGHT - 1);
  localparam logic [COL_W-1:0] OUT_COL_LAST = COL_W'(2 * (IN_WIDTH / 2) - 1);
  localparam logic [ROW_W-1:0] OUT_ROW_LAST = ROW_W'(2 * (IN_HEIGHT / 2) - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [FP32_WIDTH-1:0] pair_q, pair_d;
  logic [FP32_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [FP32_WIDTH-1:0] line_buf_q [LB_DEPTH];

  logic                  col_last, row_last, discard, emit, lb_we;
  logic [LB_AW-1:0]      lb_idx;
  logic [FP32_WIDTH-1:0] h_max, v_max, result;

  fp32_max2 u_hmax (.a(pair_q),             .b(Data_In), .y(h_max));
  fp32_max2 u_vmax (.a(line_buf_q[lb_idx]), .b(h_max),   .y(v_max));

  always_comb begin
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);
    // The trailing column/row of an odd dimension has no partner pixel.
    discard  = (W_ODD && col_last) || (H_ODD && row_last);
    lb_idx   = LB_AW'(col_q >> 1);
    emit     = Valid_In && !discard && col_q[0] && row_q[0];
    lb_we    = Valid_In && !discard && col_q[0] && !row_q[0];

`ifdef MAXPOOL_FUSED_RELU_EN
    result = v_max[FP32_SIGN_BIT] ? FP32_POS_ZERO : v_max;
`else
    result = v_max;
`endif

    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    if (Valid_In) begin
      if (!col_q[0]) pair_d = Data_In;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    valid_out_d  = emit;
    data_out_d   = emit ? result : data_out_q;
    frame_done_d = emit && (col_q == OUT_COL_LAST) && (row_q == OUT_ROW_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer holds the top-row horizontal maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf_q[lb_idx] <= h_max;
  end

  assign Data_Out   = data_out_q;
  assign Valid_Out  = valid_out_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_maxpool2d_2x2_stride2x2.sv
// Self-checking bench for maxpool2d_2x2_stride2x2 on a 5x5 frame geometry:
// window table, odd-dimension frame, random-gap frames and mid-frame reset.
module tb_maxpool2d_2x2_stride2x2;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int OW = W / 2;
  localparam int OH = H / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, frame_done;

  maxpool2d_2x2_stride2x2 #(.DATA_WIDHT(32), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in),
    .Data_Out(data_out), .Valid_Out(valid_out), .Frame_Done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] data; logic fd; int due;} exp_t;
  typedef struct {logic [31:0] p[4]; logic [31:0] y;} win_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0, checks = 0, fd_seen = 0, fd_exp = 0;
  logic [31:0] frame [H][W];
  logic [31:0] ovr_val [OH*OW];
  bit          ovr_en  [OH*OW];
  win_t        tbl [6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Sign-magnitude to signed integer; -0 maps below +0.
  function automatic logic signed [32:0] mkey(input logic [31:0] x);
    logic signed [32:0] k;
    k = $signed({2'b00, x[30:0]});
    if (x[31]) k = -k - 33'sd1;
    return k;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (mkey(b) > mkey(a)) ? b : a;
  endfunction

  function automatic logic [31:0] ref_pool(input logic [31:0] tl, input logic [31:0] tr,
                                           input logic [31:0] bl, input logic [31:0] br);
    logic [31:0] v;
    v = fmax(fmax(tl, tr), fmax(bl, br));
`ifdef MAXPOOL_FUSED_RELU_EN
    if (v[31]) v = 32'h0;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_out actual=no Valid_Out required=%h due cycle %0d", mon_e.data, mon_e.due);
      end
      if (valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_out", {31'b0, valid_out}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("data_out", data_out, mon_e.data);
          chk("frame_done", {31'b0, frame_done}, {31'b0, mon_e.fd});
          chk("latency_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (frame_done) begin
        chk("frame_done_without_valid", {31'b0, frame_done}, 32'h0);
      end
      if (frame_done) fd_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in  = $urandom;
    end
  endtask

  task automatic run_frame(input int n_pix, input int gap_pct);
    for (int i = 0; i < n_pix; i++) begin
      int   r, c, k;
      exp_t e;
      r = i / W;
      c = i % W;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = frame[r][c];
      if (r % 2 == 1 && c % 2 == 1 && r < 2*OH && c < 2*OW) begin
        k      = (r / 2) * OW + c / 2;
        e.data = ovr_en[k] ? ovr_val[k]
                           : ref_pool(frame[r-1][c-1], frame[r-1][c], frame[r][c-1], frame[r][c]);
        e.fd   = (k == OH*OW - 1);
        e.due  = cyc + 1;
        sb.push_back(e);
        if (e.fd) fd_exp++;
      end
    end
    foreach (ovr_en[k]) ovr_en[k] = 1'b0;
  endtask

  task automatic fill_random();
    foreach (frame[r, c]) frame[r][c] = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    // Windows: top-left, top-right, bottom-left, bottom-right -> pooled value.
    tbl[0].p = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000};
    tbl[1].p = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
    tbl[2].p = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    tbl[3].p = '{32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h40400000};
    tbl[4].p = '{32'hFFC00000, 32'hBF800000, 32'hC0000000, 32'hC0400000};
    tbl[5].p = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
`ifdef MAXPOOL_FUSED_RELU_EN
    tbl[0].y = 32'h00000000;
    tbl[1].y = 32'h00000000;
    tbl[2].y = 32'h00000000;
    tbl[3].y = 32'h7FC00000;
    tbl[4].y = 32'h00000000;
    tbl[5].y = 32'h40800000;
`else
    tbl[0].y = 32'hBF800000;
    tbl[1].y = 32'h00000000;
    tbl[2].y = 32'h80000000;
    tbl[3].y = 32'h7FC00000;
    tbl[4].y = 32'hBF800000;
    tbl[5].y = 32'h40800000;
`endif
    foreach (ovr_en[k]) ovr_en[k] = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_valid_out", {31'b0, valid_out}, 32'h0);
    chk("reset_frame_done", {31'b0, frame_done}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // 5x5 frame of 1.0..25.0: trailing column and row produce nothing.
    for (int n = 1; n <= W*H; n++) begin
      int e;
      logic [31:0] v;
      e = $clog2(n + 1) - 1;
      v = 32'(n) << (23 - e);
      frame[(n-1)/W][(n-1)%W] = {1'b0, 8'(127 + e), v[22:0]};
    end
    ovr_val = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};
    foreach (ovr_en[k]) ovr_en[k] = 1'b1;
    run_frame(W*H, 0);

    // Window table, each frame back-to-back with the previous.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      frame[0][0] = tbl[t].p[0];
      frame[0][1] = tbl[t].p[1];
      frame[1][0] = tbl[t].p[2];
      frame[1][1] = tbl[t].p[3];
      ovr_val[0]  = tbl[t].y;
      ovr_en[0]   = 1'b1;
      run_frame(W*H, 0);
    end
    idle(1);
    drain();

    // Two frames with random Valid_In gaps.
    fill_random();
    run_frame(W*H, 40);
    fill_random();
    run_frame(W*H, 40);
    idle(1);
    drain();

    // Abandon a frame part-way through row 3, then restart cleanly.
    fill_random();
    run_frame(3*W + 3, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst      = 1'b0;
    sb.delete();
    #1;
    chk("midreset_data_out", data_out, 32'h0);
    chk("midreset_valid_out", {31'b0, valid_out}, 32'h0);
    chk("midreset_frame_done", {31'b0, frame_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    fill_random();
    run_frame(W*H, 20);
    idle(1);
    drain();

    chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
